// File: rtl/wts_timer_pkg.sv
// Shared widths, register map and control-bit positions for the wave-table timer trigger generator.
package wts_timer_pkg;

    localparam int PERIOD_W = 12;
    localparam int ADDR_W   = 7;

    localparam logic [1:0] REG_PERIOD_L = 2'd0;
    localparam logic [1:0] REG_PERIOD_H = 2'd1;
    localparam logic [1:0] REG_MATCH    = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_RESTART = 2;

endpackage

// File: rtl/wts_timer_channel.sv
// One timer channel: period divider, wave address counter, match compare and registered trigger.
// Trigger rises one clock after the tick cycle; a restart write in a tick cycle suppresses that tick.
module wts_timer_channel
    import wts_timer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              wr_period_l,
    input  logic              wr_period_h,
    input  logic              wr_match,
    input  logic              wr_ctrl,
    input  logic [7:0]        wr_data,
    output logic              trigger,
    output logic [ADDR_W-1:0] address,
    output logic              busy
);

    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] cnt;
    logic [ADDR_W-1:0]   match;
    logic [ADDR_W-1:0]   addr;
    logic                enable;
    logic                oneshot;
    logic                armed;

    logic running;
    logic restart;
    logic step;
    logic tick;
    logic hit;

    assign running = enable & armed;
    assign restart = wr_ctrl & wr_data[CTRL_RESTART];
    assign step    = clk_en & running;
    assign tick    = step & (cnt == '0) & ~restart;
    assign hit     = tick & (addr == match);

    always_ff @(posedge clk) begin
        if (reset) begin
            period  <= '0;
            cnt     <= '0;
            match   <= '0;
            addr    <= '0;
            enable  <= 1'b0;
            oneshot <= 1'b0;
            armed   <= 1'b1;
            trigger <= 1'b0;
            address <= '0;
            busy    <= 1'b0;
        end else begin
            trigger <= hit;
            busy    <= running;

            if (hit) begin
                address <= addr;
                if (oneshot) begin
                    armed <= 1'b0;
                end
            end

            // Reload uses the period held before any write landing this cycle.
            if (step) begin
                cnt <= (cnt == '0) ? period : cnt - 1'b1;
            end
            if (tick) begin
                addr <= addr + 1'b1;
            end

            if (wr_period_l) begin
                period[7:0] <= wr_data;
            end
            if (wr_period_h) begin
                period[PERIOD_W-1:8] <= wr_data[PERIOD_W-9:0];
            end
            if (wr_match) begin
                match <= wr_data[ADDR_W-1:0];
            end
            if (wr_ctrl) begin
                enable  <= wr_data[CTRL_ENABLE];
                oneshot <= wr_data[CTRL_ONESHOT];
                if (wr_data[CTRL_RESTART]) begin
                    cnt   <= period;
                    addr  <= '0;
                    armed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wts_timer_trigger_gen.sv
// Two independent timer trigger channels behind a small byte-wide register write port.
// Triggers are registered one clock after the divided tick; writes are accepted every cycle.
module wts_timer_trigger_gen
    import wts_timer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              wr,
    input  logic              wr_ch,
    input  logic [1:0]        wr_reg,
    input  logic [7:0]        wr_data,
    output logic              timer1_trigger,
    output logic [ADDR_W-1:0] timer1_address,
    output logic              timer2_trigger,
    output logic [ADDR_W-1:0] timer2_address,
    output logic [1:0]        busy
);

    logic [1:0] sel;

    assign sel[0] = wr & ~wr_ch;
    assign sel[1] = wr &  wr_ch;

    wts_timer_channel u_ch1 (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .wr_period_l (sel[0] && (wr_reg == REG_PERIOD_L)),
        .wr_period_h (sel[0] && (wr_reg == REG_PERIOD_H)),
        .wr_match    (sel[0] && (wr_reg == REG_MATCH)),
        .wr_ctrl     (sel[0] && (wr_reg == REG_CTRL)),
        .wr_data     (wr_data),
        .trigger     (timer1_trigger),
        .address     (timer1_address),
        .busy        (busy[0])
    );

    wts_timer_channel u_ch2 (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .wr_period_l (sel[1] && (wr_reg == REG_PERIOD_L)),
        .wr_period_h (sel[1] && (wr_reg == REG_PERIOD_H)),
        .wr_match    (sel[1] && (wr_reg == REG_MATCH)),
        .wr_ctrl     (sel[1] && (wr_reg == REG_CTRL)),
        .wr_data     (wr_data),
        .trigger     (timer2_trigger),
        .address     (timer2_address),
        .busy        (busy[1])
    );

endmodule
